branch_resolve_unit: RTL

// Parametrised successor of the ID-stage branch adder: resolves BEQ/BNE/BLEZ/BGTZ/J/JAL/JR,

---
 rtl/branch_pkg.sv | 47 ++++
 rtl/branch_history_table.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit and its history table:
//   - MIPS-style opcode / funct constants for the control-transfer instructions
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - decoded control-transfer kind
//   - saturating counter update helper
// No ports (package).
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_COND = 3'd1,
        BR_J    = 3'd2,
        BR_JAL  = 3'd3,
        BR_JR   = 3'd4
    } br_kind_e;

    // Saturating 2-bit counter step: up on taken, down on not taken.
    function automatic logic [1:0] bht_next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : (ctr + 2'd1);
        end else begin
            nxt = (ctr == SNT) ? SNT : (ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
// BHT_DEPTH x 2-bit saturating direction counters.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (all counters -> WNT)
//   i_fetch_idx       asynchronous read index (fetch lookup)
//   o_fetch_pred      MSB of the addressed counter (pre-update value)
//   i_upd_en          apply one counter update at this edge
//   i_upd_idx         counter to update
//   i_upd_taken       direction resolved for the update
// -----------------------------------------------------------------------------
module branch_history_table
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_fetch_idx,
    output logic             o_fetch_pred,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_ctr [BHT_DEPTH];

    // Counter array: reset to weakly-not-taken, otherwise one saturating update per edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_ctr[i] <= WNT;
            end
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= bht_next_ctr(r_ctr[i_upd_idx], i_upd_taken);
        end else begin
            r_ctr <= r_ctr;
        end
    end

    // Read is from the array register, so a same-cycle update is not visible yet.
    assign o_fetch_pred = r_ctr[i_fetch_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves BEQ/BNE/BLEZ/BGTZ/J/JAL/JR in ID, computes the redirect target,
// registers the result for one cycle and keeps a 2-bit BHT for fetch.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_stall             freeze output registers and BHT
//   i_valid_in          ID holds a real instruction
//   i_opcode, i_funct   instruction [31:26] / [5:0]
//   i_d1, i_d2          forwarded rs / rt operands
//   i_pc_next           PC+1 of the ID instruction
//   i_pc_branch         branch offset (conditional) or absolute jump target
//   i_pred_taken        direction fetch used for this instruction
//   i_fetch_pc          PC+1 of the IF instruction (BHT lookup)
//   o_fetch_pred        combinational BHT prediction for i_fetch_pc
//   o_taken             registered: transfer resolved taken
//   o_branch_pc         registered: redirect PC (meaningful when o_mispredict)
//   o_mispredict        registered: redirect fetch and flush IF/ID
//   o_link_we           registered: JAL writes o_link_data to $31
//   o_link_data         registered: zero-extended pc_next of the JAL
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_WIDE   = 7,
    parameter int BHT_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_valid_in,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_funct,
    input  logic [31:0]        i_d1,
    input  logic [31:0]        i_d2,
    input  logic [PC_WIDE-1:0] i_pc_next,
    input  logic [PC_WIDE-1:0] i_pc_branch,
    input  logic               i_pred_taken,
    input  logic [PC_WIDE-1:0] i_fetch_pc,
    output logic               o_fetch_pred,
    output logic               o_taken,
    output logic [PC_WIDE-1:0] o_branch_pc,
    output logic               o_mispredict,
    output logic               o_link_we,
    output logic [31:0]        o_link_data
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    br_kind_e           w_kind;
    logic               w_cond;
    logic [PC_WIDE-1:0] w_cond_target;
    logic               w_taken;
    logic [PC_WIDE-1:0] w_branch_pc;
    logic               w_mispredict;
    logic               w_link_we;
    logic [31:0]        w_link_data;
    logic               w_bht_upd_en;
    logic               w_unused_fetch_hi;

    logic               r_taken;
    logic [PC_WIDE-1:0] r_branch_pc;
    logic               r_mispredict;
    logic               r_link_we;
    logic [31:0]        r_link_data;

    // Decode the instruction class; an invalid slot is treated as a non-branch.
    always_comb begin
        w_kind = BR_NONE;
        if (i_valid_in) begin
            case (i_opcode)
                OP_SPECIAL: w_kind = (i_funct == FUNCT_JR) ? BR_JR : BR_NONE;
                OP_J:       w_kind = BR_J;
                OP_JAL:     w_kind = BR_JAL;
                OP_BEQ,
                OP_BNE,
                OP_BLEZ,
                OP_BGTZ:    w_kind = BR_COND;
                default:    w_kind = BR_NONE;
            endcase
        end else begin
            w_kind = BR_NONE;
        end
    end

    // Conditional-branch comparison; BLEZ/BGTZ look at d1 only, as signed.
    always_comb begin
        w_cond = 1'b0;
        case (i_opcode)
            OP_BEQ:  w_cond = (i_d1 == i_d2);
            OP_BNE:  w_cond = (i_d1 != i_d2);
            OP_BLEZ: w_cond = ($signed(i_d1) <= $signed(32'd0));
            OP_BGTZ: w_cond = ($signed(i_d1) >  $signed(32'd0));
            default: w_cond = 1'b0;
        endcase
    end

    // Relative target wraps within the PC width (carry out discarded).
    assign w_cond_target = i_pc_next + i_pc_branch;

    // Next values for the output registers.
    always_comb begin
        w_taken      = 1'b0;
        w_branch_pc  = {PC_WIDE{1'b0}};
        w_mispredict = 1'b0;
        w_link_we    = 1'b0;
        w_link_data  = 32'd0;
        case (w_kind)
            BR_COND: begin
                w_taken      = w_cond;
                w_mispredict = w_cond ^ i_pred_taken;
                // Redirect to the correct path: the target if taken, the fall-through otherwise.
                if (w_mispredict) begin
                    w_branch_pc = w_cond ? w_cond_target : i_pc_next;
                end else begin
                    w_branch_pc = {PC_WIDE{1'b0}};
                end
            end
            BR_J: begin
                w_taken      = 1'b1;
                w_mispredict = 1'b1;
                w_branch_pc  = i_pc_branch;
            end
            BR_JAL: begin
                w_taken      = 1'b1;
                w_mispredict = 1'b1;
                w_branch_pc  = i_pc_branch;
                w_link_we    = 1'b1;
                w_link_data  = 32'(i_pc_next);
            end
            BR_JR: begin
                w_taken      = 1'b1;
                w_mispredict = 1'b1;
                w_branch_pc  = i_d1[PC_WIDE-1:0];
            end
            default: begin
                w_taken      = 1'b0;
                w_branch_pc  = {PC_WIDE{1'b0}};
                w_mispredict = 1'b0;
                w_link_we    = 1'b0;
                w_link_data  = 32'd0;
            end
        endcase
    end

    // Output registers: reset clears (drops any in-flight result), stall holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_taken      <= 1'b0;
            r_branch_pc  <= {PC_WIDE{1'b0}};
            r_mispredict <= 1'b0;
            r_link_we    <= 1'b0;
            r_link_data  <= 32'd0;
        end else if (!i_stall) begin
            r_taken      <= w_taken;
            r_branch_pc  <= w_branch_pc;
            r_mispredict <= w_mispredict;
            r_link_we    <= w_link_we;
            r_link_data  <= w_link_data;
        end else begin
            r_taken      <= r_taken;
            r_branch_pc  <= r_branch_pc;
            r_mispredict <= r_mispredict;
            r_link_we    <= r_link_we;
            r_link_data  <= r_link_data;
        end
    end

    // Only resolved conditionals train the table; jumps are never predicted.
    assign w_bht_upd_en = (w_kind == BR_COND) && !i_stall;

    branch_history_table #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_idx  (i_fetch_pc[IDX_W-1:0]),
        .o_fetch_pred (o_fetch_pred),
        .i_upd_en     (w_bht_upd_en),
        .i_upd_idx    (i_pc_next[IDX_W-1:0]),
        .i_upd_taken  (w_cond)
    );

    // Upper fetch PC bits alias onto the same counters and are intentionally ignored.
    assign w_unused_fetch_hi = ^i_fetch_pc;

    assign o_taken      = r_taken;
    assign o_branch_pc  = r_branch_pc;
    assign o_mispredict = r_mispredict;
    assign o_link_we    = r_link_we;
    assign o_link_data  = r_link_data;

endmodule
